fp_argmax_sched: RTL and testbench

- Sequencer that shares one fp16 two-operand comparator (`others`-type: a/b AXI-stream inputs; result_tvalid, index, equal outputs) across a frame of Q-values.
- Accepts a stream of Q-values, one per action, and issues pairwise compares of the running best against each new value.
- Emits the argmax action index and the max value.
- Sits between the Q-network output stage and the RL action-select/policy logic.

---
 rtl/fp_argmax_sched_if.sv | 63 ++++++
 rtl/fp_argmax_sched.sv | 152 +++++++++++++++
 tb/tb_fp_argmax_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_argmax_sched_if.sv
// rtl/fp_argmax_sched_if.sv - Q-value stream, comparator and action-result signal bundle
interface fp_argmax_sched_if #(
  parameter int EXP   = 5,
  parameter int FRA   = 10,
  parameter int IDX_W = 3
);
  localparam int DW = EXP + FRA + 1;

  // Q-value input stream
  logic [DW-1:0]    s_axis_q_tdata;
  logic             s_axis_q_tvalid;
  logic             s_axis_q_tready;
  logic             s_axis_q_tlast;

  // shared comparator operands and result
  logic [DW-1:0]    cmp_a_tdata;
  logic             cmp_a_tvalid;
  logic             cmp_a_tready;
  logic [DW-1:0]    cmp_b_tdata;
  logic             cmp_b_tvalid;
  logic             cmp_b_tready;
  logic             cmp_result_tvalid;
  logic             cmp_index;
  logic             cmp_equal;

  // argmax result stream
  logic [IDX_W-1:0] m_axis_act_tdata;
  logic [DW-1:0]    m_axis_act_max;
  logic             m_axis_act_tie;
  logic             m_axis_act_err;
  logic             m_axis_act_tvalid;
  logic             m_axis_act_tready;

  logic             busy;

  // sequencer side
  modport slave (
    input  s_axis_q_tdata, s_axis_q_tvalid, s_axis_q_tlast,
    output s_axis_q_tready,
    output cmp_a_tdata, cmp_a_tvalid,
    input  cmp_a_tready,
    output cmp_b_tdata, cmp_b_tvalid,
    input  cmp_b_tready,
    input  cmp_result_tvalid, cmp_index, cmp_equal,
    output m_axis_act_tdata, m_axis_act_max, m_axis_act_tie, m_axis_act_err, m_axis_act_tvalid,
    input  m_axis_act_tready,
    output busy
  );

  // environment side: Q source, comparator and policy sink
  modport master (
    output s_axis_q_tdata, s_axis_q_tvalid, s_axis_q_tlast,
    input  s_axis_q_tready,
    input  cmp_a_tdata, cmp_a_tvalid,
    output cmp_a_tready,
    input  cmp_b_tdata, cmp_b_tvalid,
    output cmp_b_tready,
    output cmp_result_tvalid, cmp_index, cmp_equal,
    input  m_axis_act_tdata, m_axis_act_max, m_axis_act_tie, m_axis_act_err, m_axis_act_tvalid,
    output m_axis_act_tready,
    input  busy
  );
endinterface

// File: rtl/fp_argmax_sched.sv
// rtl/fp_argmax_sched.sv - argmax sequencer sharing one fp comparator across a frame of Q-values
module fp_argmax_sched #(
  parameter int EXP   = 5,
  parameter int FRA   = 10,
  parameter int NUM   = 8,
  parameter int IDX_W = 3
) (
  input  logic               aclk,
  input  logic               aresetn,
  fp_argmax_sched_if.slave   bus
);
  localparam int DW = EXP + FRA + 1;
  // one extra bit so the count can reach NUM itself
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, FIRST, NEXT, ISSUE, WAIT, DONE} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_best;
  logic [DW-1:0]    r_cand;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] r_cand_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_tie;
  logic             r_err;
  logic             r_q_tready;
  logic             r_a_tvalid;
  logic             r_b_tvalid;
  logic             r_act_tvalid;
  logic             r_busy;

  logic             w_q_hs;
  logic             w_a_done;
  logic             w_b_done;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_q_hs    = r_q_tready & bus.s_axis_q_tvalid;
  // an operand counts as delivered once its valid has dropped or is being accepted now
  assign w_a_done  = ~r_a_tvalid | bus.cmp_a_tready;
  assign w_b_done  = ~r_b_tvalid | bus.cmp_b_tready;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  assign bus.s_axis_q_tready   = r_q_tready;
  assign bus.cmp_a_tdata       = r_best;
  assign bus.cmp_a_tvalid      = r_a_tvalid;
  assign bus.cmp_b_tdata       = r_cand;
  assign bus.cmp_b_tvalid      = r_b_tvalid;
  assign bus.m_axis_act_tdata  = r_best_idx;
  assign bus.m_axis_act_max    = r_best;
  assign bus.m_axis_act_tie    = r_tie;
  assign bus.m_axis_act_err    = r_err;
  assign bus.m_axis_act_tvalid = r_act_tvalid;
  assign bus.busy              = r_busy;

  // frame sequencer: accept Q-values, issue compares, track running best, present the result
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_best       <= '0;
      r_cand       <= '0;
      r_best_idx   <= '0;
      r_cand_idx   <= '0;
      r_cnt        <= '0;
      r_last       <= 1'b0;
      r_tie        <= 1'b0;
      r_err        <= 1'b0;
      r_q_tready   <= 1'b0;
      r_a_tvalid   <= 1'b0;
      r_b_tvalid   <= 1'b0;
      r_act_tvalid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FIRST;
          r_busy     <= 1'b1;
          r_q_tready <= 1'b1;
        end
        FIRST: begin
          if (w_q_hs) begin
            r_best     <= bus.s_axis_q_tdata;
            r_best_idx <= '0;
            r_cnt      <= CNT_W'(1);
            r_tie      <= 1'b0;
            r_err      <= 1'b0;
            if (bus.s_axis_q_tlast) begin
              r_q_tready   <= 1'b0;
              r_act_tvalid <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (w_q_hs) begin
            r_cand     <= bus.s_axis_q_tdata;
            r_cand_idx <= r_cnt[IDX_W-1:0];
            r_cnt      <= w_cnt_nxt;
            // a full frame without tlast is closed here and flagged
            if (w_cnt_nxt == CNT_W'(NUM) && !bus.s_axis_q_tlast) begin
              r_last <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_last <= bus.s_axis_q_tlast;
            end
            r_q_tready <= 1'b0;
            r_a_tvalid <= 1'b1;
            r_b_tvalid <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cmp_a_tready) r_a_tvalid <= 1'b0;
          if (bus.cmp_b_tready) r_b_tvalid <= 1'b0;
          if (w_a_done && w_b_done) r_state <= WAIT;
        end
        WAIT: begin
          if (bus.cmp_result_tvalid) begin
            // equal keeps the earlier (lower) index as the best
            if (bus.cmp_equal) begin
              r_tie <= 1'b1;
            end else if (bus.cmp_index) begin
              r_best     <= r_cand;
              r_best_idx <= r_cand_idx;
            end
            if (r_last) begin
              r_act_tvalid <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_q_tready <= 1'b1;
              r_state    <= NEXT;
            end
          end
        end
        DONE: begin
          if (bus.m_axis_act_tready) begin
            r_act_tvalid <= 1'b0;
            r_tie        <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_last       <= 1'b0;
            r_q_tready   <= 1'b1;
            r_state      <= FIRST;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_argmax_sched.sv
// tb/tb_fp_argmax_sched.sv - self-checking bench for fp_argmax_sched
module tb_fp_argmax_sched;
  localparam int EXP = 5, FRA = 10, NUM = 8, IDX_W = 3, LAT = 3;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  fp_argmax_sched_if #(.EXP(EXP), .FRA(FRA), .IDX_W(IDX_W)) bus ();

  fp_argmax_sched #(.EXP(EXP), .FRA(FRA), .NUM(NUM), .IDX_W(IDX_W)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // total order used by the comparator model: bigger key = bigger value
  function automatic logic [15:0] key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  // comparator model: per-operand ready delay, fixed latency, one result per pair
  int a_delay = 0, b_delay = 0;
  int n_cmps = 0, valid_cycles = 0, proto_err = 0;
  initial begin : cmp_model
    int a_wait, b_wait, lat_cnt;
    bit a_hs, b_hs, a_done, b_done, a_seen, b_seen;
    logic [15:0] a_first, b_first, a_cap, b_cap;
    a_wait = 0; b_wait = 0; lat_cnt = 0;
    a_hs = 0; b_hs = 0; a_done = 0; b_done = 0; a_seen = 0; b_seen = 0;
    a_first = '0; b_first = '0; a_cap = '0; b_cap = '0;
    bus.cmp_a_tready = 1'b0;
    bus.cmp_b_tready = 1'b0;
    bus.cmp_result_tvalid = 1'b0;
    bus.cmp_index = 1'b0;
    bus.cmp_equal = 1'b0;
    forever begin
      step();
      bus.cmp_result_tvalid = 1'b0;
      if (a_hs) begin a_hs = 0; a_done = 1; if (bus.cmp_a_tvalid) proto_err++; end
      if (b_hs) begin b_hs = 0; b_done = 1; if (bus.cmp_b_tvalid) proto_err++; end
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.cmp_result_tvalid = 1'b1;
          bus.cmp_index = key(b_cap) > key(a_cap);
          bus.cmp_equal = (a_cap == b_cap);
        end
      end
      if (a_done && b_done) begin
        a_done = 0; b_done = 0; lat_cnt = LAT; n_cmps++;
      end
      if (bus.cmp_a_tvalid || bus.cmp_b_tvalid) valid_cycles++;
      bus.cmp_a_tready = 1'b0;
      if (bus.cmp_a_tvalid && !a_done && !a_hs) begin
        if (!a_seen) begin a_seen = 1; a_first = bus.cmp_a_tdata; a_wait = 0; end
        else if (bus.cmp_a_tdata !== a_first) proto_err++;
        if (a_wait >= a_delay) begin
          bus.cmp_a_tready = 1'b1; a_hs = 1; a_cap = bus.cmp_a_tdata; a_seen = 0;
        end else a_wait++;
      end
      bus.cmp_b_tready = 1'b0;
      if (bus.cmp_b_tvalid && !b_done && !b_hs) begin
        if (!b_seen) begin b_seen = 1; b_first = bus.cmp_b_tdata; b_wait = 0; end
        else if (bus.cmp_b_tdata !== b_first) proto_err++;
        if (b_wait >= b_delay) begin
          bus.cmp_b_tready = 1'b1; b_hs = 1; b_cap = bus.cmp_b_tdata; b_seen = 0;
        end else b_wait++;
      end
    end
  end

  task automatic send(input logic [15:0] d, input bit last);
    int n;
    n = 0;
    bus.s_axis_q_tdata = d;
    bus.s_axis_q_tlast = last;
    bus.s_axis_q_tvalid = 1'b1;
    while (!bus.s_axis_q_tready && n < 300) begin step(); n++; end
    check("q_accept", bus.s_axis_q_tready, 1);
    step();
    bus.s_axis_q_tvalid = 1'b0;
    bus.s_axis_q_tlast = 1'b0;
  endtask

  task automatic recv(input int stall, input string tag, output logic [2:0] idx,
                      output logic [15:0] mx, output bit tie, output bit err);
    int n;
    n = 0;
    bus.m_axis_act_tready = 1'b0;
    while (!bus.m_axis_act_tvalid && n < 400) begin step(); n++; end
    check({tag, "_act_tvalid"}, bus.m_axis_act_tvalid, 1);
    idx = bus.m_axis_act_tdata;
    mx = bus.m_axis_act_max;
    tie = bus.m_axis_act_tie;
    err = bus.m_axis_act_err;
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, "_hold"}, {bus.m_axis_act_tvalid, bus.m_axis_act_tdata, bus.m_axis_act_max,
                             bus.m_axis_act_tie, bus.m_axis_act_err}, {1'b1, idx, mx, tie, err});
      check({tag, "_q_blocked"}, bus.s_axis_q_tready, 0);
    end
    bus.m_axis_act_tready = 1'b1;
    step();
    bus.m_axis_act_tready = 1'b0;
    check({tag, "_released"}, {bus.m_axis_act_tvalid, bus.s_axis_q_tready}, 2'b01);
  endtask

  logic [15:0] fv[8];

  task automatic do_frame(input int n, input bit tl, input int stall, input logic [2:0] e_idx,
                          input logic [15:0] e_max, input bit e_tie, input bit e_err,
                          input int e_cmps, input string tag);
    int c0, v0;
    logic [2:0] idx;
    logic [15:0] mx;
    bit tie, err;
    c0 = n_cmps;
    v0 = valid_cycles;
    for (int i = 0; i < n; i++) begin
      send(fv[i], tl && (i == n - 1));
      if (i == n - 1) check({tag, "_q_tready_after_last"}, bus.s_axis_q_tready, 0);
    end
    recv(stall, tag, idx, mx, tie, err);
    check({tag, "_idx"}, idx, e_idx);
    check({tag, "_max"}, mx, e_max);
    check({tag, "_tie"}, tie, e_tie);
    check({tag, "_err"}, err, e_err);
    check({tag, "_compares"}, n_cmps - c0, e_cmps);
    if (e_cmps == 0) check({tag, "_no_cmp_valid"}, valid_cycles - v0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {bus.s_axis_q_tready, bus.cmp_a_tvalid, bus.cmp_b_tvalid,
                            bus.m_axis_act_tvalid, bus.busy, bus.m_axis_act_tie,
                            bus.m_axis_act_err}, 0);
    check({tag, "_data"}, {bus.m_axis_act_tdata, bus.m_axis_act_max}, 0);
    check({tag, "_cmp_data"}, {bus.cmp_a_tdata, bus.cmp_b_tdata}, 0);
  endtask

  // behavioural reference: argmax = first index holding the overall maximum
  task automatic ref_model(input int n, input bit tl, output logic [2:0] idx, output logic [15:0] mx,
                           output bit tie, output bit err);
    logic [15:0] pm;
    idx = 0;
    for (int j = 1; j < n; j++) if (key(fv[j]) > key(fv[idx])) idx = 3'(j);
    mx = fv[idx];
    tie = 0;
    for (int j = 1; j < n; j++) begin
      pm = fv[0];
      for (int k = 1; k < j; k++) if (key(fv[k]) > key(pm)) pm = fv[k];
      if (fv[j] == pm) tie = 1;
    end
    err = (n == NUM) && !tl;
  endtask

  typedef struct {
    int          n;
    bit          tl;
    logic [15:0] v[8];
    logic [2:0]  e_idx;
    logic [15:0] e_max;
    bit          e_tie;
    bit          e_err;
    int          e_cmps;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0] r_idx;
    logic [15:0] r_max;
    bit r_tie, r_err, r_tl;
    int r_n;
    logic [15:0] pool[4];
    logic [31:0] rnd;

    tbl[0] = '{4, 1'b1, '{16'h3c00, 16'h4000, 16'hbc00, 16'h3800, 16'h0, 16'h0, 16'h0, 16'h0}, 3'd1, 16'h4000, 1'b0, 1'b0, 3};
    tbl[1] = '{1, 1'b1, '{16'hb4ea, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 3'd0, 16'hb4ea, 1'b0, 1'b0, 0};
    tbl[2] = '{3, 1'b1, '{16'h3c00, 16'h3c00, 16'h3296, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 3'd0, 16'h3c00, 1'b1, 1'b0, 2};
    tbl[3] = '{8, 1'b0, '{16'h3c00, 16'h3800, 16'h4000, 16'h3400, 16'h4200, 16'h3000, 16'hc000, 16'h4800}, 3'd7, 16'h4800, 1'b0, 1'b1, 7};
    tbl[4] = '{3, 1'b1, '{16'hc000, 16'hbc00, 16'hc400, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 3'd1, 16'hbc00, 1'b0, 1'b0, 2};
    tbl[5] = '{8, 1'b1, '{16'h3800, 16'h3c00, 16'h3c00, 16'h3a00, 16'h3c00, 16'h3000, 16'h2c00, 16'h3b00}, 3'd1, 16'h3c00, 1'b1, 1'b0, 7};
    pool = '{16'h3c00, 16'hbc00, 16'h0000, 16'h4000};

    bus.s_axis_q_tdata = '0;
    bus.s_axis_q_tvalid = 1'b0;
    bus.s_axis_q_tlast = 1'b0;
    bus.m_axis_act_tready = 1'b0;

    #2 aresetn = 1'b0;
    step();
    step();
    check_zero("reset");
    aresetn = 1'b1;
    check("busy_at_release", bus.busy, 0);
    step();
    check("busy_after_release", {bus.busy, bus.s_axis_q_tready}, 2'b11);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) fv[i] = tbl[r].v[i];
      do_frame(tbl[r].n, tbl[r].tl, 0, tbl[r].e_idx, tbl[r].e_max, tbl[r].e_tie,
               tbl[r].e_err, tbl[r].e_cmps, $sformatf("vec%0d", r));
    end

    // operands accepted at different times, output held off for 5 cycles
    a_delay = 2;
    b_delay = 4;
    fv[0] = 16'h3c00;
    fv[1] = 16'h4000;
    do_frame(2, 1'b1, 5, 3'd1, 16'h4000, 1'b0, 1'b0, 1, "stall");
    a_delay = 0;
    b_delay = 0;

    // reset while a compare is outstanding; its result lands after release
    send(16'h3c00, 1'b0);
    send(16'h4000, 1'b0);
    step();
    aresetn = 1'b0;
    #1;
    check_zero("mid_reset");
    step();
    aresetn = 1'b1;
    fv[0] = 16'h3800;
    fv[1] = 16'h3c00;
    do_frame(2, 1'b1, 0, 3'd1, 16'h3c00, 1'b0, 1'b0, 1, "post_reset");

    for (int f = 0; f < 40; f++) begin
      r_n = $urandom_range(1, NUM);
      r_tl = (r_n < NUM) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        rnd = $urandom;
        if ($urandom_range(0, 2) == 0) fv[i] = pool[$urandom_range(0, 3)];
        else fv[i] = {rnd[15], 5'($urandom_range(0, 30)), rnd[9:0]};
      end
      a_delay = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3);
      ref_model(r_n, r_tl, r_idx, r_max, r_tie, r_err);
      do_frame(r_n, r_tl, $urandom_range(0, 3), r_idx, r_max, r_tie, r_err, r_n - 1,
               $sformatf("rnd%0d", f));
    end

    check("cmp_protocol_errors", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
